// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the cache controller.
// Helpers work on a 64-bit container; callers size-cast to their own widths.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        REFILL,
        INSTALL,
        DONE
    } state_t;

    localparam int ADDR_MAX        = 64;
    localparam int WORDS_PER_BLOCK = 64;
    localparam int SET_LSB         = 6;
    localparam int TAG_LSB         = 14;

    function automatic logic [ADDR_MAX-1:0] bit_field(input logic [ADDR_MAX-1:0] a,
                                                      input int lsb, input int w);
        return (a >> lsb) & ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [ADDR_MAX-1:0] addr_tag(input logic [ADDR_MAX-1:0] a,
                                                     input int tag_lsb, input int tag_w);
        return bit_field(a, tag_lsb, tag_w);
    endfunction

    function automatic logic [ADDR_MAX-1:0] addr_set(input logic [ADDR_MAX-1:0] a,
                                                     input int set_lsb, input int set_w);
        return bit_field(a, set_lsb, set_w);
    endfunction

    function automatic logic [ADDR_MAX-1:0] addr_offset(input logic [ADDR_MAX-1:0] a,
                                                        input int off_w);
        return bit_field(a, 0, off_w);
    endfunction

    function automatic logic [ADDR_MAX-1:0] make_addr(input logic [ADDR_MAX-1:0] tag,
                                                      input logic [ADDR_MAX-1:0] set,
                                                      input logic [ADDR_MAX-1:0] offset,
                                                      input int set_w, input int off_w);
        return (tag << (set_w + off_w)) | (set << off_w) | offset;
    endfunction

endpackage

// File: rtl/cache_stats.sv
// Saturating hit/miss counters; the whole module exists only with CACHE_STATS_EN.
// A hit on the lookup that follows INSTALL is the tail of a miss and is not counted.
`ifdef CACHE_STATS_EN
module cache_stats
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        compare,
    input  logic        install,
    input  logic        hit,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    logic relookup;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            relookup   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (install) begin
                relookup <= 1'b1;
            end else if (compare) begin
                relookup <= 1'b0;
            end
            if (compare && hit && !relookup) begin
                hit_count <= sat_inc(hit_count);
            end
            if (compare && !hit) begin
                miss_count <= sat_inc(miss_count);
            end
        end
    end

endmodule
`endif

// File: rtl/cache_ctrl.sv
// Sequencing FSM for a 4-way set-associative cache: lookup, dirty writeback, refill, install.
// Optional CACHE_STATS_EN adds hit_count/miss_count outputs.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int OFFSET_WIDTH  = $clog2(WORDS_PER_BLOCK),
    parameter int SET_WIDTH     = TAG_LSB - SET_LSB,
    parameter int TAG_WIDTH     = ADDRESS_WIDTH - TAG_LSB
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    output logic                     cpu_done,
    output logic [ADDRESS_WIDTH-1:0] arr_addr,
    input  logic                     arr_hit,
    input  logic                     arr_victim_dirty,
    input  logic [TAG_WIDTH-1:0]     arr_victim_tag,
    output logic                     arr_rd,
    output logic                     arr_wr,
    output logic                     arr_fill_we,
    output logic                     arr_install,
    output logic                     arr_lru_touch,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic                     mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`endif
);

    localparam int SET_LO = OFFSET_WIDTH;
    localparam int TAG_LO = OFFSET_WIDTH + SET_WIDTH;

    state_t                  state, state_n;
    logic [OFFSET_WIDTH-1:0] beat, beat_n;
    logic                    latch_req, latch_victim;

    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic                     we_q;
    logic [TAG_WIDTH-1:0]     vtag_q;

    logic [TAG_WIDTH-1:0]     req_tag;
    logic [SET_WIDTH-1:0]     req_set;
    logic [ADDRESS_WIDTH-1:0] blk_addr, wb_addr;

    assign req_tag  = TAG_WIDTH'(addr_tag(ADDR_MAX'(addr_q), TAG_LO, TAG_WIDTH));
    assign req_set  = SET_WIDTH'(addr_set(ADDR_MAX'(addr_q), SET_LO, SET_WIDTH));
    assign blk_addr = ADDRESS_WIDTH'(make_addr(ADDR_MAX'(req_tag), ADDR_MAX'(req_set),
                                               ADDR_MAX'(beat), SET_WIDTH, OFFSET_WIDTH));
    assign wb_addr  = ADDRESS_WIDTH'(make_addr(ADDR_MAX'(vtag_q), ADDR_MAX'(req_set),
                                               ADDR_MAX'(beat), SET_WIDTH, OFFSET_WIDTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
        end
    end

    // Request and victim fields are plain data: captured on demand, never reset.
    always_ff @(posedge clk) begin
        if (latch_req) begin
            addr_q <= cpu_addr;
            we_q   <= cpu_we;
        end
        if (latch_victim) begin
            vtag_q <= arr_victim_tag;
        end
    end

    always_comb begin
        state_n       = state;
        beat_n        = beat;
        latch_req     = 1'b0;
        latch_victim  = 1'b0;
        cpu_done      = 1'b0;
        arr_addr      = '0;
        arr_rd        = 1'b0;
        arr_wr        = 1'b0;
        arr_fill_we   = 1'b0;
        arr_install   = 1'b0;
        arr_lru_touch = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    latch_req = 1'b1;
                    state_n   = COMPARE;
                end
            end
            COMPARE: begin
                arr_addr = addr_q;
                if (arr_hit) begin
                    arr_rd        = !we_q;
                    arr_wr        = we_q;
                    arr_lru_touch = 1'b1;
                    state_n       = DONE;
                end else begin
                    beat_n = '0;
                    if (arr_victim_dirty) begin
                        latch_victim = 1'b1;
                        state_n      = WRITEBACK;
                    end else begin
                        state_n = REFILL;
                    end
                end
            end
            WRITEBACK: begin
                arr_rd   = 1'b1;
                arr_addr = blk_addr;
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = wb_addr;
                if (mem_ack) begin
                    beat_n = beat + OFFSET_WIDTH'(1);
                    if (&beat) begin
                        state_n = REFILL;
                    end
                end
            end
            REFILL: begin
                arr_addr    = blk_addr;
                mem_req     = 1'b1;
                mem_addr    = blk_addr;
                arr_fill_we = mem_ack;
                if (mem_ack) begin
                    beat_n = beat + OFFSET_WIDTH'(1);
                    if (&beat) begin
                        state_n = INSTALL;
                    end
                end
            end
            INSTALL: begin
                arr_addr    = addr_q;
                arr_install = 1'b1;
                state_n     = COMPARE;
            end
            DONE: begin
                arr_addr = addr_q;
                cpu_done = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef CACHE_STATS_EN
    cache_stats u_stats (
        .clk        (clk),
        .reset      (reset),
        .compare    (state == COMPARE),
        .install    (state == INSTALL),
        .hit        (arr_hit),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl (OFFSET_WIDTH=2): stimulus queues expected events,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_cache_ctrl;

    localparam logic [1:0] EV_MEM  = 2'd0;
    localparam logic [1:0] EV_INST = 2'd1;
    localparam logic [1:0] EV_HIT  = 2'd2;
    localparam logic [1:0] EV_DONE = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] aaddr;
        logic        we;
        logic        stb;
        int          cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr;
    logic        cpu_done;
    logic [31:0] arr_addr;
    logic        arr_hit, arr_victim_dirty;
    logic [21:0] arr_victim_tag;
    logic        arr_rd, arr_wr, arr_fill_we, arr_install, arr_lru_touch;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
    logic [31:0] exp_hits, exp_misses;
`endif

    logic hit_cfg, inst_seen = 1'b0;
    logic chk_idle, chk_stats, finishing;
    int   ack_gap, ack_cnt;
    int   cyc = 0;
    int   n_cmp = 0, n_err = 0, n_timeouts = 0;
    int   b;
    ev_t  exp_q[$];
    ev_t  got, e;
    logic have, prev_stall;
    logic [31:0] prev_addr;

    cache_ctrl #(
        .ADDRESS_WIDTH(32), .OFFSET_WIDTH(2), .SET_WIDTH(8), .TAG_WIDTH(22)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_done(cpu_done),
        .arr_addr(arr_addr), .arr_hit(arr_hit), .arr_victim_dirty(arr_victim_dirty),
        .arr_victim_tag(arr_victim_tag), .arr_rd(arr_rd), .arr_wr(arr_wr),
        .arr_fill_we(arr_fill_we), .arr_install(arr_install), .arr_lru_touch(arr_lru_touch),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Array stub: a miss turns into a hit once the block has been installed.
    always @(posedge clk) begin
        if (arr_install) inst_seen <= 1'b1;
        else if (cpu_done) inst_seen <= 1'b0;
    end
    assign arr_hit = hit_cfg | inst_seen;

    // Memory responder: ack after ack_gap idle cycles of an outstanding request.
    initial begin
        mem_ack = 1'b0;
        ack_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (ack_cnt >= ack_gap) begin
                    mem_ack = 1'b1;
                    ack_cnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    ack_cnt++;
                end
            end else begin
                mem_ack = 1'b0;
                ack_cnt = 0;
            end
        end
    end

    function automatic void push_mem(input logic [31:0] a, input logic [31:0] aa, input logic we);
        exp_q.push_back('{EV_MEM, a, aa, we, 1'b1, -1});
    endfunction
    function automatic void push_tail(input logic [31:0] a, input logic we, input int done_cyc,
                                      input logic installs);
        if (installs) exp_q.push_back('{EV_INST, 32'd0, a, 1'b0, 1'b0, -1});
        exp_q.push_back('{EV_HIT, 32'd0, a, we, !we, -1});
        exp_q.push_back('{EV_DONE, 32'd0, 32'd0, 1'b0, 1'b0, done_cyc});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic we, output int base);
        cpu_addr = a;
        cpu_we   = we;
        cpu_req  = 1'b1;
        base     = cyc;
        step();
        cpu_req  = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) begin
            $display("FAIL timeout_%s: %0d events outstanding, required 0", name, exp_q.size());
            n_timeouts++;
            exp_q.delete();
        end
        step();
    endtask

    // Monitor / scoreboard
    initial begin
        prev_stall = 1'b0;
        prev_addr  = '0;
        forever begin
            @(negedge clk);
            if (chk_idle) begin
                n_cmp++;
                if ({cpu_done, arr_addr, arr_rd, arr_wr, arr_fill_we, arr_install,
                     arr_lru_touch, mem_req, mem_we, mem_addr} != '0) begin
                    n_err++;
                    $display("FAIL idle_outputs @%0d: done=%b mem_req=%b mem_addr=%h arr_addr=%h, required all 0",
                             cyc, cpu_done, mem_req, mem_addr, arr_addr);
                end
            end
            if (prev_stall && !reset) begin
                n_cmp++;
                if (!mem_req || mem_addr != prev_addr) begin
                    n_err++;
                    $display("FAIL stall_hold @%0d: mem_req=%b mem_addr=%h, required 1 %h",
                             cyc, mem_req, mem_addr, prev_addr);
                end
            end
            prev_stall = mem_req && !mem_ack && !reset;
            prev_addr  = mem_addr;
`ifdef CACHE_STATS_EN
            if (chk_stats) begin
                n_cmp++;
                if (hit_count != exp_hits || miss_count != exp_misses) begin
                    n_err++;
                    $display("FAIL stats: hit=%0d miss=%0d, required hit=%0d miss=%0d",
                             hit_count, miss_count, exp_hits, exp_misses);
                end
            end
`endif
            have = 1'b1;
            if (mem_req && mem_ack)
                got = '{EV_MEM, mem_addr, arr_addr, mem_we, mem_we ? arr_rd : arr_fill_we, -1};
            else if (arr_install)
                got = '{EV_INST, 32'd0, arr_addr, 1'b0, 1'b0, -1};
            else if (arr_lru_touch)
                got = '{EV_HIT, 32'd0, arr_addr, arr_wr, arr_rd, -1};
            else if (cpu_done)
                got = '{EV_DONE, 32'd0, 32'd0, 1'b0, 1'b0, cyc};
            else
                have = 1'b0;
            if (have) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_event @%0d: kind=%0d addr=%h aaddr=%h, required none",
                             cyc, got.kind, got.addr, got.aaddr);
                end else begin
                    e = exp_q.pop_front();
                    if (got != e) begin
                        n_err++;
                        $display("FAIL event @%0d: got kind=%0d addr=%h aaddr=%h we=%b stb=%b cyc=%0d, required kind=%0d addr=%h aaddr=%h we=%b stb=%b cyc=%0d",
                                 cyc, got.kind, got.addr, got.aaddr, got.we, got.stb, got.cyc,
                                 e.kind, e.addr, e.aaddr, e.we, e.stb, e.cyc);
                    end
                end
            end
            if (finishing) begin
                n_cmp++;
                if (exp_q.size() != 0) begin
                    n_err++;
                    $display("FAIL leftover: %0d expected events, required 0", exp_q.size());
                end
                n_cmp++;
                if (n_timeouts != 0) begin
                    n_err++;
                    $display("FAIL timeouts: %0d, required 0", n_timeouts);
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        hit_cfg = 1'b0; arr_victim_dirty = 1'b0; arr_victim_tag = '0;
        ack_gap = 0; chk_idle = 1'b0; chk_stats = 1'b0; finishing = 1'b0;
`ifdef CACHE_STATS_EN
        exp_hits = 0; exp_misses = 0;
`endif
        step();
        chk_idle = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        chk_idle = 1'b0;

        // Load hit: done two cycles after the request cycle, no memory traffic.
        hit_cfg = 1'b1;
        issue(32'h100, 1'b0, b);
        push_tail(32'h100, 1'b0, b + 2, 1'b0);
        drain(20, "hit_load");

        // Clean load miss: four refill beats, install, re-lookup.
        hit_cfg = 1'b0;
        issue(32'h200, 1'b0, b);
        for (int i = 0; i < 4; i++) push_mem(32'h200 + i, 32'h200 + i, 1'b0);
        push_tail(32'h200, 1'b0, b + 8, 1'b1);
        drain(40, "clean_miss");

        // Store hit.
        hit_cfg = 1'b1;
        issue(32'h104, 1'b1, b);
        push_tail(32'h104, 1'b1, b + 2, 1'b0);
        drain(20, "hit_store");

`ifdef CACHE_STATS_EN
        exp_hits = 2; exp_misses = 1;
        chk_stats = 1'b1;
        step();
        chk_stats = 1'b0;
`endif

        // Request held high through DONE is taken again; address changes in between.
        cpu_addr = 32'h104; cpu_we = 1'b0; cpu_req = 1'b1; b = cyc;
        push_tail(32'h104, 1'b0, b + 2, 1'b0);
        step();
        step();
        cpu_addr = 32'h108;
        push_tail(32'h108, 1'b0, b + 5, 1'b0);
        step();
        step();
        cpu_req = 1'b0;
        drain(20, "back_to_back");

        // Dirty store miss, victim tag 0x5: writeback {5,set 0xC0,beat} then refill.
        hit_cfg = 1'b0; arr_victim_dirty = 1'b1; arr_victim_tag = 22'h5;
        issue(32'h300, 1'b1, b);
        for (int i = 0; i < 4; i++) push_mem(32'h1700 + i, 32'h300 + i, 1'b1);
        for (int i = 0; i < 4; i++) push_mem(32'h300 + i, 32'h300 + i, 1'b0);
        push_tail(32'h300, 1'b1, b + 12, 1'b1);
        drain(60, "dirty_miss");
        arr_victim_dirty = 1'b0;

        // Refill with ack every third cycle.
        ack_gap = 2;
        issue(32'h240, 1'b0, b);
        for (int i = 0; i < 4; i++) push_mem(32'h240 + i, 32'h240 + i, 1'b0);
        push_tail(32'h240, 1'b0, b + 16, 1'b1);
        drain(80, "stalled_refill");

        // Reset for three cycles while a refill beat is outstanding.
        ack_gap = 1000;
        issue(32'h400, 1'b0, b);
        step();
        step();
        reset = 1'b1;
        step();
        chk_idle = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        chk_idle = 1'b0;
        ack_gap = 0;

        // Controller works normally again after the abort.
        hit_cfg = 1'b1;
        issue(32'h100, 1'b0, b);
        push_tail(32'h100, 1'b0, b + 2, 1'b0);
        drain(20, "post_reset_hit");

`ifdef CACHE_STATS_EN
        exp_hits = 1; exp_misses = 0;
        chk_stats = 1'b1;
        step();
        chk_stats = 1'b0;
`endif

        step();
        finishing = 1'b1;
    end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Sequencing FSM for the 4-way set-associative cache array.
- Accepts one CPU load/store at a time and checks hit/miss against the array.
- On a miss, writes back a dirty LRU victim word-by-word to main memory, then refills the block word-by-word and installs the tag. It then re-runs the lookup so every access completes as a hit.
- Sits between the CPU port, the cache array (tag/data/valid/dirty/LRU storage) and the main-memory port. Contains no data storage of its own.

Parameters:
- ADDRESS_WIDTH, 32, CPU/memory byte-free word address width.
- TAG_WIDTH, 18, tag field width = ADDRESS_WIDTH-SET_WIDTH-OFFSET_WIDTH.
- SET_WIDTH, 8, set index width.
- OFFSET_WIDTH, 6, word-in-block width; WORDS_PER_BLOCK = 2**OFFSET_WIDTH.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  access request; sampled only in IDLE.
- cpu_we  in  1  1=store, 0=load; latched with cpu_req.
- cpu_addr  in  ADDRESS_WIDTH  access address; latched with cpu_req.
- cpu_done  out  1  one-cycle completion pulse; load data valid from array this cycle.
- arr_addr  out  ADDRESS_WIDTH  address presented to array (latched CPU address, offset replaced by beat during WB/REFILL).
- arr_hit  in  1  array hit for arr_addr (combinational).
- arr_victim_dirty  in  1  LRU victim of set is valid and dirty.
- arr_victim_tag  in  TAG_WIDTH  tag of LRU victim.
- arr_rd  out  1  read word at arr_addr (hit load, or writeback beat).
- arr_wr  out  1  CPU store into hit way; sets dirty.
- arr_fill_we  out  1  write mem_rdata-path word into victim way at arr_addr offset.
- arr_install  out  1  victim way: tag<=latched tag, valid<=1, dirty<=0.
- arr_lru_touch  out  1  hit way LRU<=0, others +1 (saturating).
- mem_req  out  1  memory beat request, held until mem_ack.
- mem_we  out  1  1=writeback beat, 0=refill beat.
- mem_addr  out  ADDRESS_WIDTH  beat address.
- mem_ack  in  1  beat complete; ignored when mem_req=0.

Behaviour:
- Reset values: state=IDLE, beat=0, all outputs 0. Reset in any state aborts the access at the next edge. No done pulse follows. mem_req drops the cycle after the reset edge.
- Outputs are Moore-decoded from state, beat and latched fields. No output is combinational on cpu_* inputs.
- IDLE: if cpu_req, latch cpu_addr/cpu_we and go to COMPARE; otherwise stay.
- COMPARE: arr_addr = latched address.
  - If arr_hit: arr_rd=!we, arr_wr=we, arr_lru_touch=1, then go to DONE.
  - If no hit and arr_victim_dirty: latch victim tag, beat<=0, go to WRITEBACK.
  - If no hit and victim clean: beat<=0, go to REFILL.
- WRITEBACK: arr_rd=1, arr_addr={latched set index, beat}. mem_req=1, mem_we=1, mem_addr={victim tag, set, beat}. On mem_ack: beat+1. On ack at beat=WORDS_PER_BLOCK-1: beat<=0, go to REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr={latched tag, set, beat}. arr_fill_we=mem_ack. On mem_ack at the last beat, go to INSTALL.
- INSTALL: arr_install=1 for one cycle, then go to COMPARE. The re-lookup must hit.
- DONE: cpu_done=1 for one cycle, then go to IDLE. A cpu_req held through DONE is sampled again in IDLE.
- Hit latency: req sampled at edge 0; cpu_done high in cycle 2. Back-to-back hits complete every 3 cycles.
- Clean miss: 2 + W refill beats + INSTALL + COMPARE + DONE.
- Dirty miss: adds W writeback beats.
- beat is OFFSET_WIDTH bits and wraps to 0 at the transition. mem_ack on consecutive cycles advances one beat per cycle.
- Writes are write-back and write-allocate. A store miss refills and then writes on the re-lookup.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0 and saturating at 0xFFFFFFFF.
  - hit_count increments on a COMPARE hit that was not entered from INSTALL.
  - miss_count increments on each COMPARE miss.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- cache_pkg holds:
  - state enum {IDLE, COMPARE, WRITEBACK, REFILL, INSTALL, DONE};
  - localparams WORDS_PER_BLOCK, TAG_LSB, SET_LSB;
  - functions addr_tag/addr_set/addr_offset and make_addr(tag,set,offset).
- One sub-module, cache_stats (counters under CACHE_STATS_EN), instantiated only when the macro is defined.

Test Plan (OFFSET_WIDTH=2, W=4):
- Reset held 3 cycles mid-REFILL with mem_req=1 -> mem_req=0 one cycle after reset edge; state IDLE; no cpu_done.
- Load 0x100, arr_hit=1 -> arr_rd+arr_lru_touch in COMPARE; cpu_done exactly cycle 2; no mem_req.
- Load 0x200 miss, victim clean -> 4 refill beats, mem_addr 0x200..0x203, mem_we=0, arr_fill_we per ack, arr_install once, re-COMPARE, cpu_done.
- Store 0x300 miss, victim dirty tag 0x5 -> 4 writeback beats at {0x5,set,0..3} with mem_we=1, then refill, install, arr_wr on re-COMPARE, done.
- mem_ack stalls (ack every 3rd cycle during refill) -> mem_req held and mem_addr stable between acks; beat advances only on ack.
- CACHE_STATS_EN: 2 hits + 1 miss -> hit_count=2, miss_count=1; the post-install re-lookup hit is not counted.
